// File: rtl/acc_alu_unit.sv
// rtl/acc_alu_unit.sv - registered add/accumulate/MAC unit with valid/ready handshake
module acc_alu_unit #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 16,
   parameter int SATURATE  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 clear,
   output logic [ACC_WIDTH-1:0] result,
   output logic                 out_valid,
   output logic                 ovf
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] M_ADD     = 2'b00;
   localparam logic [1:0] M_ACC_ADD = 2'b01;
   localparam logic [1:0] M_ACC_SUB = 2'b10;
   localparam logic [1:0] M_MAC     = 2'b11;

   // Shifted multiplicand needs 2*WIDTH bits; one extra bit keeps acc+addend carry-free.
   localparam int PW  = 2 * WIDTH;
   localparam int EXT = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
   localparam int CW  = $clog2(WIDTH) + 1;
   localparam logic [EXT-1:0] MAX_X = {{(EXT-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

   logic [1:0]           state;
   logic [ACC_WIDTH-1:0] acc;
   logic [PW-1:0]        a_sh;
   logic [WIDTH-1:0]     b_sh;
   logic [CW-1:0]        count;

   logic [EXT-1:0]       acc_x;
   logic [EXT-1:0]       addend;
   logic [EXT-1:0]       sum_x;
   logic [EXT-1:0]       diff_x;
   logic                 is_sub;
   logic                 step_ovf;
   logic [ACC_WIDTH-1:0] step_acc;

   assign in_ready = (state == S_IDLE);
   assign result   = acc;

   // Shared accumulate step: acc +/- addend with overflow detection and optional clamping.
   always_comb begin
      acc_x    = EXT'(acc);
      addend   = EXT'(a) + EXT'(b);
      is_sub   = (mode == M_ACC_SUB);
      if (state == S_MUL) begin
         addend = EXT'(a_sh);
         is_sub = 1'b0;
      end
      sum_x    = acc_x + addend;
      diff_x   = acc_x - addend;
      step_ovf = 1'b0;
      step_acc = sum_x[ACC_WIDTH-1:0];
      if (is_sub) begin
         step_ovf = (addend > acc_x);
         step_acc = (step_ovf && (SATURATE != 0)) ? '0 : diff_x[ACC_WIDTH-1:0];
      end else begin
         step_ovf = (sum_x > MAX_X);
         step_acc = (step_ovf && (SATURATE != 0)) ? '1 : sum_x[ACC_WIDTH-1:0];
      end
   end

   // Control FSM, accumulator, shift-add registers and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         acc       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else if (ena) begin
         if (clear) begin
            state     <= S_IDLE;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     case (mode)
                        M_ADD: begin
                           acc       <= addend[ACC_WIDTH-1:0];
                           out_valid <= 1'b1;
                        end
                        M_ACC_ADD, M_ACC_SUB: begin
                           acc       <= step_acc;
                           ovf       <= ovf | step_ovf;
                           out_valid <= 1'b1;
                        end
                        M_MAC: begin
                           a_sh  <= PW'(a);
                           b_sh  <= b;
                           count <= '0;
                           state <= S_MUL;
                        end
                        default: state <= S_IDLE;
                     endcase
                  end
               end
               S_MUL: begin
                  if (b_sh[0]) begin
                     acc <= step_acc;
                     ovf <= ovf | step_ovf;
                  end
                  a_sh  <= a_sh << 1;
                  b_sh  <= b_sh >> 1;
                  count <= count + 1'b1;
                  if (count == CW'(WIDTH - 1)) state <= S_DONE;
               end
               S_DONE: begin
                  out_valid <= 1'b1;
                  state     <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
